// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the five-stage core.
// Data fields are sized for the widest supported XLEN.
package pipeline_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic                RegWrite;
        logic [1:0]          ResultSrc;
        logic                MemWrite;
        logic [2:0]          funct3;
        logic [XLEN_MAX-1:0] ALUResult;
        logic [XLEN_MAX-1:0] WriteData;
        logic [XLEN_MAX-1:0] PCPlus4;
        logic [4:0]          Rd;
        logic [XLEN_MAX-1:0] ImmExt;
    } exmem_t;

    typedef struct packed {
        logic                RegWrite;
        logic [1:0]          ResultSrc;
        logic [XLEN_MAX-1:0] ALUResult;
        logic [XLEN_MAX-1:0] ReadData;
        logic [XLEN_MAX-1:0] PCPlus4;
        logic [4:0]          Rd;
        logic [XLEN_MAX-1:0] ImmExt;
    } memwb_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data port: store shift/strobes,
// load lane select and extension, misalignment detect.
module lsu_align
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [2:0]      funct3,
    input  logic [OFFW-1:0] offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0] wdata,
    output logic [NB-1:0]   wstrb,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [OFFW-1:0] amask;
    logic [NB-1:0]   bmask;
    logic [XLEN-1:0] lane;
    logic            bad_width;

    always_comb begin
        amask = '0;
        bmask = '0;
        unique case (funct3[1:0])
            2'b00: begin
                amask = OFFW'(0);
                bmask = NB'(1);
            end
            2'b01: begin
                amask = OFFW'(1);
                bmask = NB'(3);
            end
            2'b10: begin
                amask = OFFW'(3);
                bmask = NB'(15);
            end
            default: begin
                amask = OFFW'(7);
                bmask = NB'(255);
            end
        endcase
    end

    // Doubleword accesses only exist on RV64.
    assign bad_width = (funct3[1:0] == 2'b11) && (XLEN == 32);
    assign misaligned = bad_width || (|(offset & amask));

    assign wstrb = bmask << offset;
    assign wdata = store_data << {offset, 3'b000};
    assign lane  = rsp_rdata >> {offset, 3'b000};

    always_comb begin
        load_data = lane;
        unique case (funct3)
            F3_LB:   load_data = XLEN'(signed'(lane[7:0]));
            F3_LH:   load_data = XLEN'(signed'(lane[15:0]));
            F3_LW:   load_data = XLEN'(signed'(lane[31:0]));
            F3_LBU:  load_data = XLEN'(lane[7:0]);
            F3_LHU:  load_data = XLEN'(lane[15:0]);
            F3_LWU:  load_data = XLEN'(lane[31:0]);
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding data port, stall and
// fault generation, EX/MEM to MEM/WB payload.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TIMEOUT = 255,
    localparam int NB = XLEN / 8,
    localparam int OFFW = $clog2(NB),
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  exmem_t          inputs,
    output memwb_t          outputs,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [NB-1:0]   dmem_wstrb,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            StallM,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic [XLEN-1:0] ALUResultM,
    output logic            MemFaultM
);

    mem_state_t      state, next_state;
    logic [CW-1:0]   cnt;
    logic            cnt_clr, cnt_inc, tmo;
    logic            is_load, is_store, mem_op;
    logic            misaligned, rsp_take;
    logic [XLEN-1:0] addr, load_data;
    logic            unused_bits;

    assign addr     = inputs.ALUResult[XLEN-1:0];
    assign is_store = inputs.MemWrite;
    assign is_load  = (inputs.ResultSrc == RESULT_SRC_MEM)
                    && !inputs.MemWrite;
    assign mem_op   = is_load || is_store;
    assign tmo      = (cnt == CW'(TIMEOUT));

    assign unused_bits = ^inputs.WriteData;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (inputs.funct3),
        .offset     (addr[OFFW-1:0]),
        .store_data (inputs.WriteData[XLEN-1:0]),
        .rsp_rdata  (dmem_rsp_rdata),
        .wdata      (dmem_wdata),
        .wstrb      (dmem_wstrb),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    always_comb begin
        next_state     = state;
        dmem_req_valid = 1'b0;
        StallM         = 1'b0;
        MemFaultM      = 1'b0;
        rsp_take       = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        MemFaultM = 1'b1;
                    end else if (tmo) begin
                        MemFaultM = 1'b1;
                        cnt_clr   = 1'b1;
                    end else begin
                        dmem_req_valid = 1'b1;
                        if (dmem_req_ready) begin
                            cnt_clr = 1'b1;
                            if (is_load) begin
                                next_state = WAIT;
                                StallM     = 1'b1;
                            end
                        end else begin
                            StallM  = 1'b1;
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                // A response arriving on the deadline still wins.
                if (dmem_rsp_valid) begin
                    rsp_take   = 1'b1;
                    next_state = IDLE;
                end else if (tmo) begin
                    MemFaultM  = 1'b1;
                    next_state = IDLE;
                end else begin
                    StallM  = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            dmem_req_valid = 1'b0;
            StallM         = 1'b0;
            MemFaultM      = 1'b0;
            rsp_take       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (cnt_clr || (next_state != state)) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dmem_we   = is_store;
    assign dmem_addr = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};

    assign RdM        = inputs.Rd;
    assign RegWriteM  = inputs.RegWrite;
    assign ALUResultM = addr;

    always_comb begin
        outputs           = '0;
        outputs.RegWrite  = inputs.RegWrite && !MemFaultM;
        outputs.ResultSrc = inputs.ResultSrc;
        outputs.ALUResult = inputs.ALUResult;
        outputs.PCPlus4   = inputs.PCPlus4;
        outputs.Rd        = inputs.Rd;
        outputs.ImmExt    = inputs.ImmExt;
        if (rsp_take) begin
            outputs.ReadData = XLEN_MAX'(load_data);
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed
// multi-cycle sequences and a randomized run against a model.
module tb_mem_stage;
    import pipeline_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    exmem_t      inputs;
    memwb_t      outputs;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        StallM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [31:0] ALUResultM;
    logic        MemFaultM;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .inputs         (inputs),
        .outputs        (outputs),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .StallM         (StallM),
        .RdM            (RdM),
        .RegWriteM      (RegWriteM),
        .ALUResultM     (ALUResultM),
        .MemFaultM      (MemFaultM)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_op(logic [1:0] rs, logic mw, logic [2:0] f3,
                          logic [31:0] a, logic [31:0] wd);
        inputs           = '0;
        inputs.RegWrite  = 1'b1;
        inputs.ResultSrc = rs;
        inputs.MemWrite  = mw;
        inputs.funct3    = f3;
        inputs.ALUResult = 64'(a);
        inputs.WriteData = 64'(wd);
        inputs.PCPlus4   = 64'h40;
        inputs.Rd        = 5'd7;
        inputs.ImmExt    = 64'h5;
    endtask

    task automatic bubble();
        inputs = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_load(logic [2:0] f3,
                                           logic [31:0] a,
                                           logic [31:0] rd);
        int n;
        logic [63:0] v;
        logic [63:0] m;
        n = 1 << f3[1:0];
        v = 64'(rd) >> (8 * (a % 4));
        m = (64'd1 << (8 * n)) - 64'd1;
        v = v & m;
        if (!f3[2] && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [31:0] a,
                                            logic [31:0] wd);
        logic [63:0] t;
        t = 64'(wd) << (8 * (a % 4));
        return t[31:0];
    endfunction

    function automatic logic [3:0] m_strb(logic [2:0] f3,
                                          logic [31:0] a);
        int n;
        n = 1 << f3[1:0];
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    typedef struct {
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        v;
        logic        flt;
        logic [3:0]  strb;
        logic [31:0] wdat;
        logic [31:0] addr;
    } vec_t;

    vec_t tab[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{2'b00, 1'b1, F3_LW, 32'h104, 32'hDEADBEEF,
                   1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 32'h104};
        tab[1] = '{2'b00, 1'b1, F3_LH, 32'h102, 32'h1234,
                   1'b1, 1'b0, 4'hC, 32'h12340000, 32'h100};
        tab[2] = '{2'b00, 1'b1, F3_LB, 32'h103, 32'hAB,
                   1'b1, 1'b0, 4'h8, 32'hAB000000, 32'h100};
        tab[3] = '{2'b00, 1'b1, F3_LB, 32'h101, 32'h55,
                   1'b1, 1'b0, 4'h2, 32'h00005500, 32'h100};
        tab[4] = '{2'b01, 1'b0, F3_LW, 32'h101, 32'h0,
                   1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
        tab[5] = '{2'b01, 1'b0, F3_LH, 32'h103, 32'h0,
                   1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
        tab[6] = '{2'b00, 1'b1, F3_LW, 32'h102, 32'h9,
                   1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
        tab[7] = '{2'b01, 1'b0, F3_LD, 32'h100, 32'h0,
                   1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
        tab[8] = '{2'b10, 1'b0, F3_LW, 32'h100, 32'h0,
                   1'b0, 1'b0, 4'h0, 32'h0, 32'h0};

        // Reset with a load pending: port and hazard outputs held low.
        reset = 1'b1;
        set_op(RESULT_SRC_MEM, 1'b0, F3_LW, 32'h100, 32'h0);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = '0;
        next_cycle();
        @(negedge clk);
        chk("rst.valid", dmem_req_valid, 0);
        chk("rst.stall", StallM, 0);
        chk("rst.fault", MemFaultM, 0);
        chk("rst.rdata", outputs.ReadData, 0);
        next_cycle();
        reset = 1'b0;
        bubble();

        foreach (tab[i]) begin
            set_op(tab[i].rs, tab[i].mw, tab[i].f3, tab[i].a, tab[i].wd);
            dmem_req_ready = 1'b1;
            dmem_rsp_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d.valid", i), dmem_req_valid, tab[i].v);
            chk($sformatf("v%0d.stall", i), StallM, 0);
            chk($sformatf("v%0d.fault", i), MemFaultM, tab[i].flt);
            chk($sformatf("v%0d.regwr", i), outputs.RegWrite, !tab[i].flt);
            if (tab[i].v) begin
                chk($sformatf("v%0d.we", i), dmem_we, tab[i].mw);
                chk($sformatf("v%0d.addr", i), dmem_addr, tab[i].addr);
                chk($sformatf("v%0d.strb", i), dmem_wstrb, tab[i].strb);
                chk($sformatf("v%0d.wdata", i), dmem_wdata, tab[i].wdat);
            end
            next_cycle();
        end
        bubble();
        next_cycle();

        load_seq(F3_LB, 32'hFFFFFF80, "lb");
        load_seq(F3_LBU, 32'h00000080, "lbu");
        timeout_seq();
        reset_seq();
        random_run(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic load_seq(logic [2:0] f3, logic [31:0] want, string nm);
        int stalls;
        bit done;
        stalls = 0;
        done = 0;
        set_op(RESULT_SRC_MEM, 1'b0, f3, 32'h103, 32'h0);
        dmem_req_ready = 1'b1;
        for (int c = 0; c < 10 && !done; c++) begin
            dmem_rsp_valid = (c == 3);
            dmem_rsp_rdata = (c == 3) ? 32'h80FFFF7F : 32'h0;
            @(negedge clk);
            if (c == 0) chk({nm, ".req"}, dmem_req_valid, 1);
            if (c == 1) chk({nm, ".noreq"}, dmem_req_valid, 0);
            if (StallM) begin
                stalls++;
            end else begin
                done = 1;
                chk({nm, ".rdata"}, outputs.ReadData, 64'(want));
            end
            next_cycle();
        end
        chk({nm, ".done"}, done, 1);
        chk({nm, ".stalls"}, stalls, 3);
        bubble();
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk({nm, ".idle_rd"}, outputs.ReadData, 0);
        next_cycle();
    endtask

    task automatic timeout_seq();
        int stalls;
        bit done;
        stalls = 0;
        done = 0;
        set_op(2'b00, 1'b1, F3_LW, 32'h104, 32'h1);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (StallM) begin
                stalls++;
                chk("tmo.fault_early", MemFaultM, 0);
            end else begin
                done = 1;
                chk("tmo.fault", MemFaultM, 1);
                chk("tmo.valid", dmem_req_valid, 0);
                chk("tmo.regwr", outputs.RegWrite, 0);
            end
            next_cycle();
        end
        chk("tmo.done", done, 1);
        chk("tmo.stalls", stalls, TMO);
        bubble();
        @(negedge clk);
        chk("tmo.pulse", MemFaultM, 0);
        next_cycle();
    endtask

    task automatic reset_seq();
        set_op(RESULT_SRC_MEM, 1'b0, F3_LW, 32'h200, 32'h0);
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rw.accept", StallM, 1);
        next_cycle();
        reset = 1'b1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("rw.r_valid", dmem_req_valid, 0);
        chk("rw.r_stall", StallM, 0);
        chk("rw.r_fault", MemFaultM, 0);
        next_cycle();
        reset = 1'b0;
        bubble();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rw.stale_rd", outputs.ReadData, 0);
        chk("rw.stale_stall", StallM, 0);
        chk("rw.stale_valid", dmem_req_valid, 0);
        next_cycle();
        // Only an IDLE FSM raises a request for this load.
        set_op(RESULT_SRC_MEM, 1'b0, F3_LW, 32'h200, 32'h0);
        @(negedge clk);
        chk("rw.idle_req", dmem_req_valid, 1);
        chk("rw.idle_rd", outputs.ReadData, 0);
        next_cycle();
        reset = 1'b1;
        bubble();
        dmem_rsp_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic random_run(int ncyc);
        bit busy;
        bit hold;
        bit ld, st, rw;
        bit e_valid, e_stall, e_flt;
        logic [31:0] e_rd;
        int w, n;
        bit mis;
        logic [1:0] rs;
        logic mw;
        logic [2:0] f3;
        logic [31:0] a, wd;
        logic [4:0] rd;
        busy = 0;
        hold = 0;
        w = 0;
        rs = '0;
        mw = 0;
        f3 = '0;
        a = '0;
        wd = '0;
        rd = '0;
        rw = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!hold) begin
                int k;
                k = $urandom_range(0, 9);
                wd = $urandom;
                rd = 5'($urandom);
                rw = 1'($urandom);
                a = $urandom & 32'hFFF;
                if (k < 4) begin
                    rs = RESULT_SRC_MEM;
                    mw = 0;
                    f3 = 3'($urandom_range(0, 6));
                end else if (k < 8) begin
                    rs = 2'b00;
                    mw = 1;
                    f3 = 3'($urandom_range(0, 3));
                end else begin
                    rs = 2'($urandom_range(0, 1)) << 1;
                    mw = 0;
                    f3 = 3'($urandom_range(0, 7));
                end
                n = 1 << f3[1:0];
                if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
                set_op(rs, mw, f3, a, wd);
                inputs.Rd = rd;
                inputs.RegWrite = rw;
            end
            ld = (rs == RESULT_SRC_MEM) && !mw;
            st = mw;
            n = 1 << f3[1:0];
            mis = ((a % n) != 0) || (f3[1:0] == 2'b11);
            dmem_req_ready = ($urandom_range(0, 9) < 7);
            dmem_rsp_valid = busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            dmem_rsp_rdata = $urandom;

            e_valid = 0;
            e_stall = 0;
            e_flt = 0;
            e_rd = '0;
            if (busy) begin
                if (dmem_rsp_valid) begin
                    e_rd = m_load(f3, a, dmem_rsp_rdata);
                    busy = 0;
                    w = 0;
                end else if (w == TMO) begin
                    e_flt = 1;
                    busy = 0;
                    w = 0;
                end else begin
                    e_stall = 1;
                    w++;
                end
            end else if (ld || st) begin
                if (mis) begin
                    e_flt = 1;
                end else if (w == TMO) begin
                    e_flt = 1;
                    w = 0;
                end else begin
                    e_valid = 1;
                    if (dmem_req_ready) begin
                        w = 0;
                        if (ld) begin
                            e_stall = 1;
                            busy = 1;
                        end
                    end else begin
                        e_stall = 1;
                        w++;
                    end
                end
            end

            @(negedge clk);
            chk($sformatf("r%0d.valid", c), dmem_req_valid, e_valid);
            chk($sformatf("r%0d.stall", c), StallM, e_stall);
            chk($sformatf("r%0d.fault", c), MemFaultM, e_flt);
            chk($sformatf("r%0d.rdata", c), outputs.ReadData, 64'(e_rd));
            chk($sformatf("r%0d.regwr", c), outputs.RegWrite, rw && !e_flt);
            chk($sformatf("r%0d.rdm", c), RdM, rd);
            if (e_valid) begin
                chk($sformatf("r%0d.addr", c), dmem_addr, a & ~32'h3);
                chk($sformatf("r%0d.we", c), dmem_we, st);
                if (st) begin
                    chk($sformatf("r%0d.strb", c), dmem_wstrb, m_strb(f3, a));
                    chk($sformatf("r%0d.wdata", c), dmem_wdata, m_wdata(a, wd));
                end
            end
            hold = e_stall;
            next_cycle();
        end
        bubble();
        dmem_rsp_valid = 1'b0;
    endtask

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage: consumes the EX/MEM register contents (`exmem_t`) and produces the MEM/WB payload (`memwb_t`). Drives a single-outstanding valid/ready data-memory port, aligns store data and byte strobes, and extracts and extends load data. Raises `StallM` to the hazard unit while an access is in flight. Flags misaligned accesses and memory timeouts.

## Interface
- `XLEN`, 32: datapath width; 32 or 64 only.
- `TIMEOUT`, 255: cycles waiting on `dmem_req_ready` or `dmem_rsp_valid` before a fault; must be ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `inputs`  in  `exmem_t`  EX/MEM register: RegWrite, ResultSrc, MemWrite, funct3, ALUResult, WriteData, PCPlus4, Rd, ImmExt.
- `outputs`  out  `memwb_t`  RegWrite, ResultSrc, ALUResult, ReadData, PCPlus4, Rd, ImmExt.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  memory accepts request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  XLEN  `ALUResult` with the low log2(XLEN/8) bits cleared.
- `dmem_wdata`  out  XLEN  store data shifted to its byte lane.
- `dmem_wstrb`  out  XLEN/8  byte-enable.
- `dmem_rsp_valid`  in  1  load data valid; ignored outside WAIT.
- `dmem_rsp_rdata`  in  XLEN  aligned read word.
- `StallM`  out  1  to hazard unit; stalls all stages upstream of MEM/WB and bubbles MEM/WB.
- `RdM`, `RegWriteM`  out  5, 1  to hazard unit for forwarding.
- `ALUResultM`  out  XLEN  forwarding value to EX.
- `MemFaultM`  out  1  one-cycle pulse: misaligned access or timeout.

## Operation
- Load: `ResultSrc == 2'b01`. Store: `MemWrite`. A bubble has both deasserted and issues no request.
- funct3 widths: 000/100 byte, 001/101 half, 010/110 word, 011 double (XLEN=64 only). Loads sign-extend for 0xx and zero-extend for 1xx.
- Misaligned when the address is not a multiple of the access size, or when funct3 011 is used with XLEN=32: no request; `MemFaultM` pulses; `outputs.RegWrite` forced 0; no stall.
- FSM `mem_state_t`: IDLE, WAIT.
  - IDLE, aligned memory op: `dmem_req_valid` = 1 combinationally.
    - Store with ready: completes this cycle, `StallM` = 0.
    - Load with ready: go to WAIT, `StallM` = 1.
    - Not ready: `StallM` = 1; stay in IDLE.
  - WAIT: `StallM` = 1 until `dmem_rsp_valid`. In the response cycle, `outputs.ReadData` = extracted `dmem_rsp_rdata`, `StallM` = 0, next state IDLE.
- Request fields stay stable while valid and not ready; this follows from `StallM` holding EX/MEM.
- Timeout counter: cleared on every state change and on each accepted request. It increments in each stalled cycle. When it reaches `TIMEOUT`: `MemFaultM` pulses, `outputs.RegWrite` forced 0, `StallM` drops, FSM returns to IDLE, and `dmem_req_valid` drops that cycle.
- Passthrough from `inputs` to `outputs`: RegWrite (unless forced 0), ResultSrc, ALUResult, PCPlus4, Rd, ImmExt.
- `RdM`, `RegWriteM` and `ALUResultM` mirror `inputs`.
- `outputs.ReadData` = 0 outside a load-response cycle.

## Timing
- Reset: state IDLE, counter 0. While `reset` is high, `dmem_req_valid`, `StallM` and `MemFaultM` are forced 0.
- Reset in WAIT abandons the access. A later stale `dmem_rsp_valid` is ignored because the FSM is in IDLE.
- Latency: a store with ready set completes in 0 extra cycles. A load adds N+1 stall cycles, where N = cycles from acceptance to the response (N ≥ 0).
- `dmem_rsp_valid` in the same cycle as acceptance is not permitted; memory responds at least 1 cycle later.
- All outputs except `state` and the counter are combinational from `inputs`, `state` and the memory inputs.
- A load in WAIT followed by a store in the next cycle: the store may issue in the cycle after the response.

## Structure
- `pipeline_pkg` gains:
  - `memwb_t`
  - `mem_state_t`
  - funct3 localparams (`F3_LB` … `F3_LD`)
  - `RESULT_SRC_MEM = 2'b01`
- Sub-module `lsu_align`, combinational: store lane shift and strobe generation, load lane select and extension, misalignment detect. It is instantiated once; the FSM and counter stay in `mem_stage`.

## Test plan
- SW, address 0x104, data 0xDEADBEEF, ready=1: `wstrb`=0xF, `addr`=0x104, `StallM`=0 throughout, `we`=1.
- LB, address 0x103, memory returns 0x80FF_FF7F after 2 cycles: `StallM` high for 3 cycles; `ReadData`=0xFFFFFF80. The same case as LBU gives 0x00000080.
- SH to 0x102 with data 0x1234: `wdata`=0x12340000, `wstrb`=0xC.
- LW to 0x101: no request; `MemFaultM` pulses once; `outputs.RegWrite`=0; `StallM`=0.
- `TIMEOUT`=4, ready held low: `StallM` high for 4 cycles, then `MemFaultM` pulses and `dmem_req_valid` drops.
- Reset asserted during WAIT, then a stale `dmem_rsp_valid`: all outputs zero, FSM in IDLE, response ignored.
